// File: rtl/fetch_issue_queue.sv
// Fetch-to-issue decoupling queue: one outstanding cache request, predecode,
// static branch prediction, RVC stepping and flush discard of stale responses.
module fetch_issue_queue #(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          PREDICT_MODE = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_pipline,
    input  logic [31:0] reset_PC_to,
    input  logic        jalr_just_done,
    input  logic [31:0] jalr_resulting_PC,
    input  logic        issue_space_available,
    output logic        issue_valid,
    output logic [31:0] issue_PC,
    output logic [31:0] issue_ins,
    output logic [31:0] issue_predicted_PC,
    output logic        issue_is_compressed,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_done,
    input  logic [31:0] fetch_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW:0] DEPTH_R = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pred;
        logic        comp;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] count;
    logic [PW:0]   reserved;
    logic [31:0]   fetch_pc;
    logic          outstanding;
    logic          drop;
    logic          wait_jalr;
    logic          empty;
    logic          pop;
    logic          push;
    logic          launch;
    entry_t        head_e;

    logic        comp;
    logic [1:0]  quad;
    logic [2:0]  f3;
    logic [6:0]  op;
    logic [31:0] step;
    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic [31:0] imm_cj;
    logic [31:0] imm_cb;
    logic        w_jal;
    logic        w_br;
    logic        w_jalr;
    logic        c_j;
    logic        c_br;
    logic        c_jr;
    logic [31:0] next_pc;
    logic        jalr_hit;

    assign count    = tail - head;
    assign reserved = {1'b0, count} + {{PW{1'b0}}, outstanding};
    assign empty    = (head == tail);
    assign launch   = !outstanding && !wait_jalr && (reserved < DEPTH_R);
    assign pop      = issue_valid && issue_space_available;
    assign push     = rdy_in && !flush_pipline && fetch_done
                      && outstanding && !drop;

    assign head_e              = mem[head[AW-1:0]];
    assign issue_valid         = rdy_in && !empty;
    assign issue_PC            = empty ? 32'h0 : head_e.pc;
    assign issue_ins           = empty ? 32'h0 : head_e.ins;
    assign issue_predicted_PC  = empty ? 32'h0 : head_e.pred;
    assign issue_is_compressed = !empty && head_e.comp;
    assign fetch_req           = outstanding;

    always_comb begin
        comp   = (fetch_data[1:0] != 2'b11);
        quad   = fetch_data[1:0];
        f3     = fetch_data[15:13];
        op     = fetch_data[6:0];
        step   = comp ? 32'd2 : 32'd4;
        imm_j  = {{12{fetch_data[31]}}, fetch_data[19:12],
                  fetch_data[20], fetch_data[30:21], 1'b0};
        imm_b  = {{20{fetch_data[31]}}, fetch_data[7],
                  fetch_data[30:25], fetch_data[11:8], 1'b0};
        imm_cj = {{21{fetch_data[12]}}, fetch_data[8],
                  fetch_data[10:9], fetch_data[6], fetch_data[7],
                  fetch_data[2], fetch_data[11], fetch_data[5:3], 1'b0};
        imm_cb = {{24{fetch_data[12]}}, fetch_data[6:5],
                  fetch_data[2], fetch_data[11:10],
                  fetch_data[4:3], 1'b0};
        w_jal  = !comp && (op == 7'b1101111);
        w_br   = !comp && (op == 7'b1100011);
        w_jalr = !comp && (op == 7'b1100111);
        c_j    = comp && (quad == 2'b01)
                 && ((f3 == 3'b101) || (f3 == 3'b001));
        c_br   = comp && (quad == 2'b01) && (f3[2:1] == 2'b11);
        c_jr   = comp && (quad == 2'b10) && (f3 == 3'b100)
                 && (fetch_data[6:2] == 5'd0)
                 && (fetch_data[11:7] != 5'd0);
        next_pc  = fetch_addr + step;
        jalr_hit = 1'b0;
        unique case (1'b1)
            w_jal: next_pc = fetch_addr + imm_j;
            c_j:   next_pc = fetch_addr + imm_cj;
            w_br: begin
                if (PREDICT_MODE == 1 && imm_b[31])
                    next_pc = fetch_addr + imm_b;
            end
            c_br: begin
                if (PREDICT_MODE == 1 && imm_cb[31])
                    next_pc = fetch_addr + imm_cb;
            end
            w_jalr, c_jr: jalr_hit = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (push)
            mem[tail[AW-1:0]] <= '{pc: fetch_addr, ins: fetch_data,
                                   pred: next_pc, comp: comp};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head        <= '0;
            tail        <= '0;
            fetch_pc    <= RESET_PC;
            fetch_addr  <= RESET_PC;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            wait_jalr   <= 1'b0;
        end else if (rdy_in) begin
            if (flush_pipline) begin
                head      <= '0;
                tail      <= '0;
                fetch_pc  <= reset_PC_to;
                wait_jalr <= 1'b0;
                // In-flight request keeps its address; its answer is junk.
                if (outstanding) begin
                    if (fetch_done) begin
                        outstanding <= 1'b0;
                        drop        <= 1'b0;
                    end else begin
                        drop <= 1'b1;
                    end
                end else begin
                    outstanding <= 1'b1;
                    fetch_addr  <= reset_PC_to;
                end
            end else begin
                if (pop)
                    head <= head + 1'b1;
                if (fetch_done && outstanding) begin
                    outstanding <= 1'b0;
                    drop        <= 1'b0;
                    if (!drop) begin
                        tail      <= tail + 1'b1;
                        fetch_pc  <= next_pc;
                        wait_jalr <= jalr_hit;
                    end
                end else if (launch) begin
                    outstanding <= 1'b1;
                    fetch_addr  <= fetch_pc;
                end
                if (jalr_just_done && wait_jalr) begin
                    fetch_pc  <= jalr_resulting_PC;
                    wait_jalr <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Directed bench for fetch_issue_queue with a one-cycle halfword-addressed
// instruction cache model.
module tb_fetch_issue_queue;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        flush_pipline = 1'b0;
    logic [31:0] reset_PC_to = 32'h0;
    logic        jalr_just_done = 1'b0;
    logic [31:0] jalr_resulting_PC = 32'h0;
    logic        issue_space_available = 1'b0;
    logic        fetch_done = 1'b0;
    logic [31:0] fetch_data = 32'h0;

    logic        issue_valid;
    logic [31:0] issue_PC;
    logic [31:0] issue_ins;
    logic [31:0] issue_predicted_PC;
    logic        issue_is_compressed;
    logic        fetch_req;
    logic [31:0] fetch_addr;

    logic        v0;
    logic [31:0] pc0;
    logic [31:0] ins0;
    logic [31:0] pred0;
    logic        comp0;
    logic        req0;
    logic [31:0] addr0;

    logic [15:0] hw [0:2047];
    logic [10:0] idx;
    logic        cache_en = 1'b1;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk_in = ~clk_in;

    fetch_issue_queue #(.DEPTH(4), .RESET_PC(32'h0), .PREDICT_MODE(1)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .flush_pipline(flush_pipline), .reset_PC_to(reset_PC_to),
        .jalr_just_done(jalr_just_done),
        .jalr_resulting_PC(jalr_resulting_PC),
        .issue_space_available(issue_space_available),
        .issue_valid(issue_valid), .issue_PC(issue_PC),
        .issue_ins(issue_ins), .issue_predicted_PC(issue_predicted_PC),
        .issue_is_compressed(issue_is_compressed),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_done(fetch_done), .fetch_data(fetch_data)
    );

    fetch_issue_queue #(.DEPTH(4), .RESET_PC(32'h0), .PREDICT_MODE(0)) u_dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .flush_pipline(flush_pipline), .reset_PC_to(reset_PC_to),
        .jalr_just_done(jalr_just_done),
        .jalr_resulting_PC(jalr_resulting_PC),
        .issue_space_available(issue_space_available),
        .issue_valid(v0), .issue_PC(pc0),
        .issue_ins(ins0), .issue_predicted_PC(pred0),
        .issue_is_compressed(comp0),
        .fetch_req(req0), .fetch_addr(addr0),
        .fetch_done(fetch_done), .fetch_data(fetch_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put16(input logic [31:0] a, input logic [15:0] v);
        hw[a[11:1]] = v;
    endtask

    task automatic put32(input logic [31:0] a, input logic [31:0] v);
        hw[a[11:1]]         = v[15:0];
        hw[a[11:1] + 11'd1] = v[31:16];
    endtask

    task automatic fill_nops();
        for (int i = 0; i < 1024; i++)
            put32(32'(i * 4), 32'h0000_0013);
    endtask

    // Cache answers one cycle after seeing a request.
    task automatic tick();
        fetch_done = cache_en && rdy_in && fetch_req;
        idx        = fetch_addr[11:1];
        fetch_data = {hw[idx + 11'd1], hw[idx]};
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        fetch_done = 1'b0;
        flush_pipline = 1'b0;
        jalr_just_done = 1'b0;
        rdy_in = 1'b1;
        issue_space_available = 1'b0;
        cache_en = 1'b1;
        fill_nops();
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic next_req();
        int n;
        n = 0;
        while (fetch_req && n < 20) begin tick(); n++; end
        while (!fetch_req && n < 40) begin tick(); n++; end
        chk("req_wait", {31'b0, fetch_req}, 32'd1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!issue_valid && n < 40) begin tick(); n++; end
        chk("valid_wait", {31'b0, issue_valid}, 32'd1);
    endtask

    task automatic flush_to(input logic [31:0] pc);
        flush_pipline = 1'b1;
        reset_PC_to = pc;
        tick();
        flush_pipline = 1'b0;
    endtask

    initial begin
        // Reset state and NOP stream filling a stalled queue
        fill_nops();
        #1 rst_in = 1'b1;
        #1;
        chk("rst_valid", {31'b0, issue_valid}, 32'd0);
        chk("rst_req", {31'b0, fetch_req}, 32'd0);
        chk("rst_addr", fetch_addr, 32'h0);
        chk("rst_pc", issue_PC, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            next_req();
            chk("fill_addr", fetch_addr, 32'(k * 4));
        end
        repeat (4) tick();
        chk("full_noreq", {31'b0, fetch_req}, 32'd0);
        issue_space_available = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_v", {31'b0, issue_valid}, 32'd1);
            chk("drain_pc", issue_PC, 32'(k * 4));
            tick();
        end
        issue_space_available = 1'b0;

        // Compressed stepping
        do_reset();
        put16(32'h0, 16'h0001);
        put16(32'h2, 16'h4501);
        wait_valid();
        repeat (4) tick();
        chk("c0_pc", issue_PC, 32'h0);
        chk("c0_pred", issue_predicted_PC, 32'h2);
        chk("c0_comp", {31'b0, issue_is_compressed}, 32'd1);
        chk("c0_ins", {16'h0, issue_ins[15:0]}, 32'h0001);
        issue_space_available = 1'b1;
        tick();
        issue_space_available = 1'b0;
        chk("c1_pc", issue_PC, 32'h2);
        chk("c1_pred", issue_predicted_PC, 32'h4);
        chk("c1_comp", {31'b0, issue_is_compressed}, 32'd1);

        // Static branch prediction in both modes
        do_reset();
        put32(32'h20, 32'hFE00_0CE3);
        put32(32'h18, 32'h0000_0463);
        flush_to(32'h20);
        wait_valid();
        chk("bb_pc", issue_PC, 32'h20);
        chk("bb_ins", issue_ins, 32'hFE00_0CE3);
        chk("bb_pred_btfn", issue_predicted_PC, 32'h18);
        chk("bb_pred_nt", pred0, 32'h24);
        next_req();
        chk("bb_next_addr", fetch_addr, 32'h18);
        tick();
        issue_space_available = 1'b1;
        tick();
        issue_space_available = 1'b0;
        chk("bf_pc", issue_PC, 32'h18);
        chk("bf_pred", issue_predicted_PC, 32'h1C);

        // JALR stall and resolution
        do_reset();
        put32(32'h40, 32'h0000_8067);
        flush_to(32'h40);
        wait_valid();
        chk("jalr_pc", issue_PC, 32'h40);
        chk("jalr_pred", issue_predicted_PC, 32'h44);
        repeat (5) tick();
        chk("jalr_noreq", {31'b0, fetch_req}, 32'd0);
        jalr_just_done = 1'b1;
        jalr_resulting_PC = 32'h100;
        tick();
        jalr_just_done = 1'b0;
        next_req();
        chk("jalr_target", fetch_addr, 32'h100);
        tick();
        jalr_just_done = 1'b1;
        jalr_resulting_PC = 32'h300;
        tick();
        jalr_just_done = 1'b0;
        chk("jalr_ign_req", {31'b0, fetch_req}, 32'd1);
        chk("jalr_ign_addr", fetch_addr, 32'h104);

        // Flush with an outstanding request, then flush on fetch_done
        do_reset();
        for (int k = 0; k < 4; k++) next_req();
        chk("fl_fill_addr", fetch_addr, 32'hC);
        tick();
        issue_space_available = 1'b1;
        tick();
        issue_space_available = 1'b0;
        cache_en = 1'b0;
        tick();
        chk("fl_req", {31'b0, fetch_req}, 32'd1);
        chk("fl_addr", fetch_addr, 32'h10);
        flush_to(32'h200);
        chk("fl_valid", {31'b0, issue_valid}, 32'd0);
        chk("fl_hold_req", {31'b0, fetch_req}, 32'd1);
        chk("fl_hold_addr", fetch_addr, 32'h10);
        cache_en = 1'b1;
        tick();
        chk("fl_drop_valid", {31'b0, issue_valid}, 32'd0);
        chk("fl_drop_req", {31'b0, fetch_req}, 32'd0);
        next_req();
        chk("fl_new_addr", fetch_addr, 32'h200);
        wait_valid();
        chk("fl_new_pc", issue_PC, 32'h200);
        next_req();
        chk("fc_addr", fetch_addr, 32'h204);
        flush_to(32'h300);
        chk("fc_valid", {31'b0, issue_valid}, 32'd0);
        chk("fc_req", {31'b0, fetch_req}, 32'd0);
        next_req();
        chk("fc_new_addr", fetch_addr, 32'h300);
        wait_valid();
        chk("fc_new_pc", issue_PC, 32'h300);

        // rdy_in freeze and asynchronous reset mid-request
        do_reset();
        issue_space_available = 1'b1;
        repeat (4) tick();
        chk("rdy_pre_v", {31'b0, issue_valid}, 32'd1);
        chk("rdy_pre_pc", issue_PC, 32'h4);
        chk("rdy_pre_req", {31'b0, fetch_req}, 32'd0);
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rdy_lo_v", {31'b0, issue_valid}, 32'd0);
            chk("rdy_lo_addr", fetch_addr, 32'h4);
            chk("rdy_lo_req", {31'b0, fetch_req}, 32'd0);
        end
        rdy_in = 1'b1;
        #1;
        chk("rdy_up_v", {31'b0, issue_valid}, 32'd1);
        chk("rdy_up_pc", issue_PC, 32'h4);
        tick();
        chk("rdy_r_req", {31'b0, fetch_req}, 32'd1);
        chk("rdy_r_addr", fetch_addr, 32'h8);
        chk("rdy_r_v", {31'b0, issue_valid}, 32'd0);
        tick();
        chk("rdy_r_pc", issue_PC, 32'h8);
        tick();
        chk("mid_req", {31'b0, fetch_req}, 32'd1);
        chk("mid_addr", fetch_addr, 32'hC);
        rst_in = 1'b1;
        #1;
        chk("async_req", {31'b0, fetch_req}, 32'd0);
        chk("async_addr", fetch_addr, 32'h0);
        chk("async_v", {31'b0, issue_valid}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
